// File: rtl/event_toggle_tx_pkg.sv
// Shared definitions for the toggle-based CDC event transmitter.
package event_toggle_tx_pkg;

    // Transfer FSM: idle, or one event in flight awaiting the receiver's ack toggle.
    typedef enum logic {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } state_e;

    // An ack synchroniser shallower than this is not metastability-safe.
    localparam int unsigned SyncStagesMin = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage reset-to-0 synchroniser for a single asynchronous level.
module sync_ff #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/event_toggle_tx.sv
// Transmit side of a toggle-based event CDC channel with a saturating pending-event queue.
module event_toggle_tx
    import event_toggle_tx_pkg::*;
#(
    parameter int unsigned CntWidth   = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                event_in_i,
    output logic                req_toggle_o,
    input  logic                ack_toggle_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CntWidth-1:0] pending_o,
    output logic                overflow_o,
    input  logic                clr_overflow_i
);

    // Never build a synchroniser shallower than the safe minimum.
    localparam int unsigned SyncDepth =
        (SyncStages < SyncStagesMin) ? SyncStagesMin : SyncStages;

    localparam logic [CntWidth-1:0] PendMax = '1;
    localparam logic [CntWidth-1:0] PendOne = CntWidth'(1);

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [CntWidth-1:0] pending_q, pending_d;
    logic                ack_sync;

    sync_ff #(
        .Stages (SyncDepth)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_toggle_i),
        .q_o    (ack_sync)
    );

    // Next-state logic: launch, queueing, ack detection and sticky overflow.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;

        if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // A queued event goes first; a same-cycle new event takes its queue slot.
                if (event_in_i || (pending_q != '0)) begin
                    req_d   = ~req_q;
                    state_d = StWaitAck;
                    if ((pending_q != '0) && !event_in_i) begin
                        pending_d = pending_q - PendOne;
                    end
                end
            end
            StWaitAck: begin
                if (event_in_i) begin
                    if (pending_q == PendMax) begin
                        overflow_d = 1'b1;  // set wins over clear
                    end else begin
                        pending_d = pending_q + PendOne;
                    end
                end
                if (ack_sync == req_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards the in-flight and queued events.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
        end
    end

    assign req_toggle_o = req_q;
    assign busy_o       = (state_q == StWaitAck);
    assign done_o       = done_q;
    assign pending_o    = pending_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_event_toggle_tx.sv
// Self-checking bench for event_toggle_tx with a model receiver and a launch scoreboard.
module tb_event_toggle_tx;

    localparam int CW   = 2;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          ev    = 1'b0;
    logic          ack   = 1'b0;
    logic          clr   = 1'b0;
    logic          req;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [CW-1:0] pend;

    int errors = 0;
    int checks = 0;
    int flips  = 0;
    int dones  = 0;
    int viol   = 0;
    int acc    = 0;
    int drops  = 0;
    int rx_delay = 5;
    int rx_cnt   = 0;
    bit rx_hold  = 1'b0;
    bit sb_q[$];  // expected req_toggle level for each accepted, not yet acknowledged event

    always #5 clk = ~clk;

    event_toggle_tx #(
        .CntWidth   (CW),
        .SyncStages (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .event_in_i     (ev),
        .req_toggle_o   (req),
        .ack_toggle_i   (ack),
        .busy_o         (busy),
        .done_o         (done),
        .pending_o      (pend),
        .overflow_o     (ovf),
        .clr_overflow_i (clr)
    );

    // Model receiver: echoes req_toggle onto ack_toggle rx_delay cycles after it changes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack    = 1'b0;
                rx_cnt = 0;
            end else if (rx_hold || (req === ack)) begin
                rx_cnt = 0;
            end else if (rx_cnt >= rx_delay) begin
                ack    = req;
                rx_cnt = 0;
            end else begin
                rx_cnt++;
            end
        end
    end

    // Monitor: counts req flips and done pulses, and ack changes seen while idle.
    initial begin
        logic prev_req;
        logic prev_ack;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req !== prev_req) flips++;
                if (done === 1'b1) dones++;
                if ((ack !== prev_ack) && (busy !== 1'b1)) viol++;
            end
            prev_req = req;
            prev_ack = ack;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // One clock of stimulus with scoreboard push (on accept) and pop/compare (on done).
    task automatic step(input bit e);
        bit exp;
        if (e) begin
            if (sb_q.size() < PMAX + 1) begin
                acc++;
                sb_q.push_back(acc[0]);
            end else begin
                drops++;
            end
        end
        ev = e;
        @(posedge clk);
        #1;
        ev = 1'b0;
        if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_done: got done=1 expected no transfer outstanding");
            end else begin
                exp = sb_q.pop_front();
                if (req !== exp) begin
                    errors++;
                    $display("FAIL sb_req: got %0b expected %0b", req, exp);
                end
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (((sb_q.size() != 0) || (busy !== 1'b0)) && (n < budget)) begin
            step(1'b0);
            n++;
        end
        checks++;
        if ((sb_q.size() != 0) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL %s_drain: got %0d outstanding expected 0", name, sb_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b expected 0", req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
        if (pend !== '0) begin errors++; $display("FAIL rst_pend: got %0d expected 0", pend); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        if (req !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b expected 0", req); end
    endtask

    task automatic test_single();
        int f0, d0, n, maxp;
        f0 = flips; d0 = dones; maxp = 0;
        rx_hold = 1'b0; rx_delay = 5;
        step(1'b1);
        checks += 3;
        if (req !== 1'b1) begin errors++; $display("FAIL single_req: got %0b expected 1", req); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
        if (pend !== '0) begin errors++; $display("FAIL single_pend: got %0d expected 0", pend); end
        n = 0;
        while ((busy === 1'b1) && (n < 40)) begin
            step(1'b0);
            if (int'(pend) > maxp) maxp = int'(pend);
            n++;
        end
        repeat (5) step(1'b0);
        @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b expected 0", busy); end
        if (dones - d0 != 1) begin errors++; $display("FAIL single_done: got %0d expected 1", dones - d0); end
        if (flips - f0 != 1) begin errors++; $display("FAIL single_flips: got %0d expected 1", flips - f0); end
        if (maxp != 0) begin errors++; $display("FAIL single_maxpend: got %0d expected 0", maxp); end
    endtask

    task automatic test_back_to_back();
        int f0, d0;
        logic r0;
        f0 = flips; d0 = dones; r0 = req;
        rx_delay = 5;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        checks += 2;
        if (pend !== CW'(2)) begin errors++; $display("FAIL b2b_pend: got %0d expected 2", pend); end
        if (req !== ~r0) begin errors++; $display("FAIL b2b_req: got %0b expected %0b", req, ~r0); end
        drain("b2b", 150);
        checks += 3;
        if (dones - d0 != 3) begin errors++; $display("FAIL b2b_done: got %0d expected 3", dones - d0); end
        if (flips - f0 != 3) begin errors++; $display("FAIL b2b_flips: got %0d expected 3", flips - f0); end
        if (pend !== '0) begin errors++; $display("FAIL b2b_pend_end: got %0d expected 0", pend); end
    endtask

    task automatic test_overflow();
        int f0, d0;
        f0 = flips; d0 = dones;
        rx_hold = 1'b1;
        repeat (4) step(1'b1);
        checks += 2;
        if (pend !== CW'(PMAX)) begin errors++; $display("FAIL ovf_pend4: got %0d expected %0d", pend, PMAX); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0", ovf); end
        step(1'b1);
        checks += 2;
        if (pend !== CW'(PMAX)) begin errors++; $display("FAIL ovf_pend5: got %0d expected %0d", pend, PMAX); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ovf); end
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        checks += 2;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_prio: got %0b expected 1", ovf); end
        if (pend !== CW'(PMAX)) begin errors++; $display("FAIL ovf_pend6: got %0d expected %0d", pend, PMAX); end
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b expected 0", ovf); end
        rx_hold = 1'b0;
        rx_delay = 2;
        drain("ovf", 200);
        checks += 2;
        if (dones - d0 != 4) begin errors++; $display("FAIL ovf_done: got %0d expected 4", dones - d0); end
        if (flips - f0 != 4) begin errors++; $display("FAIL ovf_flips: got %0d expected 4", flips - f0); end
    endtask

    task automatic test_same_cycle();
        int n;
        logic r0;
        rx_hold = 1'b1;
        repeat (3) step(1'b1);
        rx_delay = 0;
        rx_hold = 1'b0;
        n = 0;
        while ((done !== 1'b1) && (n < 20)) begin
            step(1'b0);
            n++;
        end
        r0 = req;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL same_idle: got busy=%0b expected 0", busy); end
        if (pend !== CW'(2)) begin errors++; $display("FAIL same_pend_pre: got %0d expected 2", pend); end
        step(1'b1);
        checks += 3;
        if (pend !== CW'(2)) begin errors++; $display("FAIL same_pend: got %0d expected 2", pend); end
        if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %0b expected 1", busy); end
        if (req !== ~r0) begin errors++; $display("FAIL same_req: got %0b expected %0b", req, ~r0); end
        drain("same", 200);
    endtask

    task automatic test_reset_mid();
        int d0;
        rx_hold = 1'b1;
        repeat (3) step(1'b1);
        checks++;
        if (pend !== CW'(2)) begin errors++; $display("FAIL mid_pend_pre: got %0d expected 2", pend); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (req !== 1'b0) begin errors++; $display("FAIL mid_req: got %0b expected 0", req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %0b expected 0", done); end
        if (pend !== '0) begin errors++; $display("FAIL mid_pend: got %0d expected 0", pend); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %0b expected 0", ovf); end
        sb_q.delete();
        acc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx_hold = 1'b0;
        rx_delay = 3;
        d0 = dones;
        step(1'b1);
        checks += 2;
        if (req !== 1'b1) begin errors++; $display("FAIL mid_relaunch_req: got %0b expected 1", req); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_relaunch_busy: got %0b expected 1", busy); end
        drain("mid", 100);
        checks++;
        if (dones - d0 != 1) begin errors++; $display("FAIL mid_done_cnt: got %0d expected 1", dones - d0); end
    endtask

    task automatic test_random();
        int f0, d0, a0, dr0, v0;
        f0 = flips; d0 = dones; a0 = acc; dr0 = drops; v0 = viol;
        for (int i = 0; i < 10000; i++) begin
            rx_delay = $urandom_range(0, 6);
            step($urandom_range(0, 2) == 0);
        end
        drain("rand", 400);
        checks += 5;
        if (dones - d0 != flips - f0) begin
            errors++; $display("FAIL rand_flip_done: got %0d flips expected %0d", flips - f0, dones - d0);
        end
        if (dones - d0 != acc - a0) begin
            errors++; $display("FAIL rand_accepted: got %0d done expected %0d", dones - d0, acc - a0);
        end
        if (ovf !== logic'(drops > dr0)) begin
            errors++; $display("FAIL rand_ovf: got %0b expected %0b", ovf, drops > dr0);
        end
        if (viol != v0) begin
            errors++; $display("FAIL rand_ack_idle: got %0d expected 0", viol - v0);
        end
        if (pend !== '0) begin errors++; $display("FAIL rand_pend: got %0d expected 0", pend); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_same_cycle();
        test_reset_mid();
        test_random();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL ack_in_idle: got %0d expected 0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
